// File: rtl/ps2_host_tx_if.sv
// Command-side handshake between a keyboard configuration client and ps2_host_tx.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       rx_inhibit;
  logic       done;
  logic       ack_ok;
  logic       err;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, busy, rx_inhibit, done, ack_ok, err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, busy, rx_inhibit, done, ack_ok, err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 10-bit frame, ack, bus-idle wait.
// Define PS2_TX_RETRY_EN to retry a NACKed or timed-out byte up to twice before reporting failure.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe,
  ps2_host_tx_if.slave cmd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [2:0]    csync_q;
  logic [1:0]    dsync_q;
  logic          fe, clk_s, data_s;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    idx_q, idx_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          ack_ok_q, ack_ok_d;
  logic          err_q, err_d;
  logic          fail, nack, retry_ok, busy;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]    attempt_q, attempt_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csync_q <= 3'b111;
      dsync_q <= 2'b11;
    end else begin
      csync_q <= {csync_q[1:0], ps2_clk_in};
      dsync_q <= {dsync_q[0], ps2_data_in};
    end
  end

  assign fe     = csync_q[2] & ~csync_q[1];
  assign clk_s  = csync_q[2];
  assign data_s = dsync_q[1];

`ifdef PS2_TX_RETRY_EN
  // A failure during the final bus-idle wait is never retried: the device already acked.
  assign retry_ok = (attempt_q != 2'd2) && (state_q != S_WAIT_IDLE);
`else
  assign retry_ok = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    idx_d    = idx_q;
    inh_d    = inh_q;
    to_d     = to_q;
    done_d   = 1'b0;
    ack_ok_d = ack_ok_q;
    err_d    = err_q;
    fail     = 1'b0;
    nack     = 1'b0;
`ifdef PS2_TX_RETRY_EN
    attempt_d = attempt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd.tx_valid) begin
          frame_d  = {1'b1, ~^cmd.tx_data, cmd.tx_data};
          ack_ok_d = 1'b0;
          err_d    = 1'b0;
          inh_d    = '0;
          state_d  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          attempt_d = '0;
`endif
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          inh_d   = '0;
          idx_d   = '0;
          state_d = S_RTS;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      S_RTS: begin
        if (fe) begin
          idx_d   = 4'd1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (fe) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fe) begin
          if (data_s) begin
            fail = 1'b1;
            nack = 1'b1;
          end else begin
            ack_ok_d = 1'b1;
            state_d  = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An edge on the terminal-count cycle restarts the window instead of timing out.
    if (state_q inside {S_RTS, S_SEND, S_ACK, S_WAIT_IDLE}) begin
      if (fe) begin
        to_d = '0;
      end else begin
        to_d = to_q + 1'b1;
        if (to_q == TO_LAST && !done_d) fail = 1'b1;
      end
    end else begin
      to_d = '0;
    end

    if (fail) begin
      if (retry_ok) begin
`ifdef PS2_TX_RETRY_EN
        attempt_d = attempt_q + 1'b1;
`endif
        inh_d    = '0;
        ack_ok_d = 1'b0;
        state_d  = S_INHIBIT;
      end else begin
        err_d    = 1'b1;
        ack_ok_d = 1'b0;
        if (nack) begin
          state_d = S_WAIT_IDLE;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    end

    // Frame bit n lives at frame_q[n-1]; the stop bit (1) releases data on its own.
    clk_oe_d  = (state_d == S_INHIBIT);
    data_oe_d = 1'b0;
    if (state_d == S_RTS)       data_oe_d = 1'b1;
    else if (state_d == S_SEND) data_oe_d = ~frame_q[idx_d - 4'd1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      inh_q     <= '0;
      to_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      inh_q     <= inh_d;
      to_q      <= to_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      ack_ok_q  <= ack_ok_d;
      err_q     <= err_d;
    end
  end

`ifdef PS2_TX_RETRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) attempt_q <= '0;
    else     attempt_q <= attempt_d;
  end
`endif

  assign busy           = (state_q != S_IDLE);
  assign ps2_clk_oe     = clk_oe_q;
  assign ps2_data_oe    = data_oe_q;
  assign cmd.tx_ready   = ~busy;
  assign cmd.busy       = busy;
  assign cmd.rx_inhibit = busy;
  assign cmd.done       = done_q;
  assign cmd.ack_ok     = ack_ok_q;
  assign cmd.err        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with an open-collector PS/2 keyboard model.
module tb_ps2_host_tx;
  localparam int unsigned INH = 40;
  localparam int unsigned TO  = 1000;
  localparam int H        = 20;
  localparam int RTS_WAIT = TO + INH + 200;
`ifdef PS2_TX_RETRY_EN
  localparam int N_ATT = 3;
`else
  localparam int N_ATT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_oe, ps2_data_oe;
  logic clk_line, data_line;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx_if cmd ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .cmd        (cmd)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic ack_ok;
    logic err;
    int   inh;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int vectors = 0;
  int miscompares = 0;
  int track_bad = 0;
  int inh_cnt = 0;
  int fall_cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame bits 1..10 as the keyboard should see them: data LSB first, odd parity, stop.
  function automatic logic [10:1] ref_frame(input logic [7:0] b);
    logic [10:1] f;
    for (int k = 1; k <= 8; k++) f[k] = b[k-1];
    f[9]  = (($countones(b) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic dev_frame(input logic [7:0] b, input bit nack, input int stop_after,
                           input bit stop_low);
    logic [10:1] exp;
    int w;
    exp = ref_frame(b);
    w = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && w < RTS_WAIT) begin
      @(negedge clk);
      w++;
    end
    check("rts_seen", (w < RTS_WAIT), 1);
    if (w >= RTS_WAIT) return;
    repeat (5) @(negedge clk);
    check("start_bit", data_line, 0);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) dev_data_low = !nack;
      repeat (4) @(negedge clk);
      dev_clk_low = 1'b1;
      fall_cyc = int'(cyc);
      repeat (H) @(negedge clk);
      if (k == stop_after && stop_low) return;
      dev_clk_low = 1'b0;
      if (k <= 10) check($sformatf("frame_bit%0d_of_%02h", k, b), data_line, exp[k]);
      if (k == stop_after) return;
      repeat (H) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic issue(input logic [7:0] b);
    cmd.tx_data  = b;
    cmd.tx_valid = 1'b1;
    @(negedge clk);
    cmd.tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !cmd.tx_ready) && w < 600) begin
      @(negedge clk);
      w++;
    end
    check("transfer_completes", (w < 600), 1);
  endtask

  task automatic run_transfer(input logic [7:0] b, input logic [2:0] nack_mask);
    int used;
    bit ok;
    used = N_ATT;
    ok = 1'b0;
    for (int a = 0; a < N_ATT; a++) begin
      if (!ok && !nack_mask[a]) begin
        used = a + 1;
        ok = 1'b1;
      end
    end
    exp_q.push_back('{ok, !ok, int'(INH) * used});
    issue(b);
    for (int a = 0; a < used; a++) dev_frame(b, nack_mask[a], 0, 1'b0);
    wait_done();
  endtask

  initial begin
    int w;
    int elapsed;
    logic [7:0] b;
    logic [2:0] m;

    cmd.tx_valid = 1'b0;
    cmd.tx_data  = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          inh_cnt = 0;
        end else begin
          if (ps2_clk_oe) inh_cnt++;
          if (cmd.rx_inhibit !== cmd.busy || cmd.tx_ready !== !cmd.busy) track_bad++;
          if (cmd.done) begin
            check("done_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              mon_e = exp_q.pop_front();
              check("ack_ok", cmd.ack_ok, mon_e.ack_ok);
              check("err", cmd.err, mon_e.err);
              check("inhibit_cycles", inh_cnt, mon_e.inh);
              check("clk_oe_at_done", ps2_clk_oe, 0);
              check("data_oe_at_done", ps2_data_oe, 0);
              check("tx_ready_at_done", cmd.tx_ready, 1);
            end
            inh_cnt = 0;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_tx_ready", cmd.tx_ready, 1);
    check("rst_busy", cmd.busy, 0);
    check("rst_rx_inhibit", cmd.rx_inhibit, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_done", cmd.done, 0);
    check("rst_ack_ok", cmd.ack_ok, 0);
    check("rst_err", cmd.err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_transfer(8'hED, 3'b000);

    exp_q.push_back('{1'b1, 1'b0, int'(INH)});
    issue(8'hF4);
    cmd.tx_valid = 1'b1;
    cmd.tx_data  = 8'h55;
    repeat (10) @(negedge clk);
    check("tx_ready_low_in_transfer", cmd.tx_ready, 0);
    cmd.tx_valid = 1'b0;
    dev_frame(8'hF4, 1'b0, 0, 1'b0);
    wait_done();
    repeat (50) @(negedge clk);
    check("no_second_frame", ps2_clk_oe, 0);
    check("idle_after_f4", cmd.busy, 0);

    run_transfer(8'hFF, 3'b111);

    exp_q.push_back('{1'b0, 1'b1, int'(INH) * N_ATT});
    issue(8'hA5);
    for (int a = 0; a < N_ATT; a++) begin
      dev_frame(8'hA5, 1'b0, 4, 1'b0);
      if (a == 0) begin
        w = 0;
        while (!(cmd.done || ps2_clk_oe) && w < int'(TO) + 200) begin
          @(negedge clk);
          w++;
        end
        elapsed = int'(cyc) - fall_cyc;
        check("timeout_window_ok", (elapsed >= int'(TO) + 2 && elapsed <= int'(TO) + 4), 1);
      end
    end
    wait_done();

    issue(8'h00);
    dev_frame(8'h00, 1'b0, 5, 1'b1);
    check("data_oe_before_rst", ps2_data_oe, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_clk_oe", ps2_clk_oe, 0);
    check("midrst_data_oe", ps2_data_oe, 0);
    check("midrst_busy", cmd.busy, 0);
    check("midrst_tx_ready", cmd.tx_ready, 1);
    @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_transfer(8'hF3, 3'b000);

    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      m[0] = ($urandom_range(0, 3) == 0);
      m[1] = ($urandom_range(0, 3) == 0);
      m[2] = ($urandom_range(0, 3) == 0);
      run_transfer(b, m);
    end

    check("rx_inhibit_tracks_busy", track_bad, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 command transmitter/sequencer for the keyboard link.
- Used to configure the keyboard: set LEDs (0xED + arg), set typematic rate (0xF3 + arg), reset (0xFF), enable (0xF4).
- Owns the open-collector drive of ps2_clk/ps2_data.
- Asserts rx_inhibit so the existing scan-code receiver ignores bus activity during a host transfer.

Parameters:
- INHIBIT_CYCLES, 10000: clk cycles ps2_clk is held low before request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: max clk cycles between device falling edges or waiting for bus idle (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ps2_clk_in  in  1  raw PS/2 clock line level.
- ps2_data_in  in  1  raw PS/2 data line level.
- ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release.
- ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release.
- tx_valid  in  1  command byte request.
- tx_data  in  8  command byte.
- tx_ready  out  1  high only in IDLE; a transfer starts when tx_valid && tx_ready.
- busy  out  1  high in every state except IDLE.
- rx_inhibit  out  1  equals busy; the receiver holds its bit counter at 0 while high.
- done  out  1  one-cycle pulse at transfer end (success or failure).
- ack_ok  out  1  valid with done: 1 = device acked; held until the next transfer starts.
- err  out  1  valid with done: 1 = NACK or timeout; held until the next transfer starts.

Behaviour:
- Synchronization and edge detect:
  - ps2_clk_in passes through a 3-flop synchronizer (reset value 3'b111). Falling edge fe = sync[2:1]==2'b10.
  - ps2_data_in passes through a 2-flop synchronizer (reset value 2'b11).
- Reset: asynchronous. All outputs 0 except tx_ready=1. State=IDLE, counters 0. Reset mid-transfer releases both lines immediately.
- Accept: in IDLE, tx_valid && tx_ready latches tx_data and computes parity = ~^tx_data (odd parity). Clears ack_ok/err. Next state is INHIBIT. tx_valid outside IDLE is ignored; no queuing.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0. Cycle counter runs 0..INHIBIT_CYCLES-1, then goes to RTS.
- RTS: ps2_data_oe=1 (start bit 0) and ps2_clk_oe=0 in the same cycle. The bit index is cleared to 0.
- SEND, frame index n=1..10 advanced on each fe:
  - On fe n, drive frame bit n: n=1..8 data LSB first; n=9 parity; n=10 stop (ps2_data_oe=0).
  - For a data/parity bit b, ps2_data_oe = ~b.
  - The first fe after RTS is n=1. After fe 10, go to ACK.
- ACK: at the next fe, sample synchronized data. 0 = ack (ack_ok=1), 1 = NACK (err=1). Go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronized clk==1 and data==1 for 1 cycle. Then pulse done and return to IDLE. Both oe are 0 throughout.
- Timeout: a counter runs in RTS/SEND/ACK/WAIT_IDLE and is cleared on every fe. Reaching TIMEOUT_CYCLES releases both lines, sets err=1, ack_ok=0, pulses done and goes to IDLE.
- Simultaneous events: a fe in the same cycle as the timeout terminal count counts as an edge (timeout suppressed). The state transition to IDLE and the done pulse occur in the same cycle.
- Latency, best case: INHIBIT_CYCLES + 1 cycles to RTS, then 11 device clocks to ACK, then bus-idle detect plus 1 cycle to done.
- Scope: the block never reads the device response byte (0xFA/0xFE). The scan-code receiver decodes it once rx_inhibit drops.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- When defined: on NACK or timeout, re-enter INHIBIT with the same byte, up to 2 retries.
  - done pulses only after success or final failure; err=1 only after the 3rd attempt fails.
  - A 2-bit attempt counter is cleared on accept.
- When undefined: single attempt; failure reported on the first NACK/timeout.

Test Plan:
1. tx_data=0xED, device model clocks 11 edges and acks low → data bits 1,0,1,1,0,1,1,1 driven on fe1..fe8; parity 1; stop releases data; done pulse with ack_ok=1, err=0; ps2_clk_oe high exactly INHIBIT_CYCLES cycles.
2. tx_data=0xF4, device acks → parity bit 0; tx_ready low until done; second tx_valid during transfer ignored (exactly one frame on bus).
3. tx_data=0xFF, device leaves data high at 11th fe (NACK) → err=1, ack_ok=0, one done pulse; with PS2_TX_RETRY_EN: 3 INHIBIT phases then err=1.
4. Device stops clocking after fe 4 → after TIMEOUT_CYCLES (set 1000 in bench) both oe=0, err=1, done pulse, tx_ready=1.
5. rst asserted mid-SEND (fe 5) → ps2_clk_oe=ps2_data_oe=0 same cycle, busy=0, tx_ready=1; next 0xF3 transfers cleanly.
6. rx_inhibit tracks busy across a full 0xED transfer; receiver emits no spurious key events during the transfer.
